mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline, directly downstream of the EX/MEM pipeline registers.
- Consumes EX/MEM outputs, runs load/store transactions on a valid/ready data-memory port, and resolves the branch decision.
- Generates the pipeline stall and owns the MEM/WB register that feeds write-back.

Parameters:
- TIMEOUT, 255: max cycles waiting in REQ or RSP before abort; 1..255.
- XLEN, 32: data/address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-low.
- inPCBranch  in  XLEN  branch target from EX/MEM.
- inZero  in  1  ALU zero flag.
- inALUOutput  in  XLEN  ALU result; memory address.
- inReadData2  in  XLEN  store data.
- inRd  in  5  destination register.
- inRegWrite, inMemtoReg, inBranch, inMemWrite, inMemRead  in  1 each  control bits.
- dmemReqValid  out  1  request valid.
- dmemReqReady  in  1  request accepted.
- dmemAddr  out  XLEN  request address.
- dmemWData  out  XLEN  store data.
- dmemWe  out  1  1 = store, 0 = load.
- dmemRspValid  in  1  load data valid.
- dmemRData  in  XLEN  load data.
- stall  out  1  freeze upstream; drives EX/MEM en as !stall.
- pcSrc  out  1  take branch.
- pcBranch  out  XLEN  branch target, passed through combinationally.
- wbReadData, wbALUOutput  out  XLEN  MEM/WB data.
- wbRd  out  5  MEM/WB destination register.
- wbRegWrite, wbMemtoReg  out  1  MEM/WB control.
- memErr  out  1  sticky timeout flag.

Behaviour:
- Reset (rst=0, async): state IDLE; timeout counter 0; all wb* outputs 0; memErr 0; dmemReqValid 0; stall 0.
  - Reset mid-transaction drops dmemReqValid immediately.
  - A dmemRspValid arriving after reset is ignored.
- memop = inMemRead | inMemWrite. If both are set, the store has priority (dmemWe=1).
- States: IDLE, REQ, RSP, DONE.
- IDLE:
  - memop=0: stall=0; MEM/WB captures inputs at next edge (latency 1).
  - memop=1: stall=1; next state REQ.
- REQ:
  - dmemReqValid=1; dmemAddr=inALUOutput; dmemWData=inReadData2; dmemWe=inMemWrite. All held stable until the handshake; stall=1.
  - On dmemReqValid & dmemReqReady: store -> DONE; load -> RSP.
- RSP:
  - stall=1; dmemReqValid=0.
  - Response is accepted only from the cycle after the handshake.
  - On dmemRspValid: latch dmemRData into an internal load buffer; -> DONE.
- DONE:
  - stall=0; next state IDLE.
  - MEM/WB captures controls, plus the load buffer (load) or 0 (store) into wbReadData.
- Minimum latency with zero-wait memory: store 3 cycles, load 4 cycles, from first visible cycle to MEM/WB capture.
- Stall cycles: MEM/WB loads a bubble (wbRegWrite=0, wbMemtoReg=0; data fields don't-care, held).
  - Guarantees no repeated register write.
- Timeout: an 8-bit counter clears on entering REQ and on REQ->RSP, and increments each cycle in REQ/RSP.
  - At count == TIMEOUT-1 without completion: set memErr (sticky until reset), deassert dmemReqValid, go to DONE.
  - Load data becomes 0; wbRegWrite is still captured as decoded.
- pcSrc = inBranch & inZero & (state == IDLE) & !memop. pcSrc is 0 during any stall.
- No back-to-back overlap: DONE always returns to IDLE, and the next instruction is examined in IDLE.

Decomposition:
- Shared package: state encoding (IDLE=0, REQ=1, RSP=2, DONE=3), TIMEOUT default, XLEN.
- One sub-module, memwb_regs: MEM/WB register with a load-enable and a bubble input.
  - Reset (async active-low) clears all fields.
  - Mirrors the existing inter-stage register style.

Test Plan:
- ALU op (inRegWrite=1, inRd=5, inALUOutput=0x1234, no memop) -> stall never 1; next edge wbRd=5, wbALUOutput=0x1234, wbRegWrite=1.
- Load at 0x100 with dmemReqReady=1 and dmemRspValid one cycle later, dmemRData=0xDEADBEEF:
  - stall=1 for 3 cycles.
  - MEM/WB then wbReadData=0xDEADBEEF, wbMemtoReg=1.
  - Bubbles (wbRegWrite=0) on the stall cycles.
- Store with dmemReqReady held 0 for 4 cycles:
  - dmemReqValid, dmemAddr and dmemWData stay stable throughout.
  - Completes the cycle after ready=1; wbRegWrite=0.
- Branch inBranch=1, inZero=1, inPCBranch=0x40 -> pcSrc=1 and pcBranch=0x40 the same cycle. With inZero=0 -> pcSrc=0.
- Load, ready never asserted, TIMEOUT=8 -> memErr=1 after 8 REQ cycles; wbReadData=0; state returns to IDLE.
- rst pulsed low while in RSP -> all outputs 0 immediately; a subsequent dmemRspValid is ignored; stall=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: state encoding, default
// widths and limits, and small decode helpers.
package mem_stage_pkg;

   localparam int XLEN_DEFAULT    = 32;
   localparam int TIMEOUT_DEFAULT = 255;
   localparam int CNT_W           = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Any instruction that touches data memory.
   function automatic logic is_memop(input logic mem_read, input logic mem_write);
      return mem_read | mem_write;
   endfunction

endpackage

// File: rtl/mem_stage_memwb_regs.sv
// MEM/WB inter-stage register: loads a full entry when enabled, otherwise
// turns into a bubble (controls cleared, data fields held) when asked.
module memwb_regs
   import mem_stage_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            bubble,
   input  logic [XLEN-1:0] inReadData,
   input  logic [XLEN-1:0] inALUOutput,
   input  logic [4:0]      inRd,
   input  logic            inRegWrite,
   input  logic            inMemtoReg,
   output logic [XLEN-1:0] outReadData,
   output logic [XLEN-1:0] outALUOutput,
   output logic [4:0]      outRd,
   output logic            outRegWrite,
   output logic            outMemtoReg
);

   logic [XLEN-1:0] read_data_q, read_data_d;
   logic [XLEN-1:0] alu_out_q,   alu_out_d;
   logic [4:0]      rd_q,        rd_d;
   logic            reg_write_q, reg_write_d;
   logic            mem_to_reg_q, mem_to_reg_d;

   // Next entry: full load, bubble (controls off, data held), or hold.
   always_comb begin
      // NOTE: every _d starts as its _q so no path through this block can infer a latch.
      read_data_d  = read_data_q;
      alu_out_d    = alu_out_q;
      rd_d         = rd_q;
      reg_write_d  = reg_write_q;
      mem_to_reg_d = mem_to_reg_q;
      if (en) begin
         read_data_d  = inReadData;
         alu_out_d    = inALUOutput;
         rd_d         = inRd;
         reg_write_d  = inRegWrite;
         mem_to_reg_d = inMemtoReg;
      end else if (bubble) begin
         reg_write_d  = 1'b0;
         mem_to_reg_d = 1'b0;
      end
   end

   // Register storage with asynchronous clear of every field.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         read_data_q  <= '0;
         alu_out_q    <= '0;
         rd_q         <= '0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
         read_data_q  <= read_data_d;
         alu_out_q    <= alu_out_d;
         rd_q         <= rd_d;
         reg_write_q  <= reg_write_d;
         mem_to_reg_q <= mem_to_reg_d;
      end
   end

   assign outReadData  = read_data_q;
   assign outALUOutput = alu_out_q;
   assign outRd        = rd_q;
   assign outRegWrite  = reg_write_q;
   assign outMemtoReg  = mem_to_reg_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: runs one load/store per instruction over a
// valid/ready data port, stalls upstream meanwhile, resolves the branch and
// feeds the MEM/WB register. Waits longer than TIMEOUT abort with memErr.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT,
   parameter int XLEN    = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] inPCBranch,
   input  logic            inZero,
   input  logic [XLEN-1:0] inALUOutput,
   input  logic [XLEN-1:0] inReadData2,
   input  logic [4:0]      inRd,
   input  logic            inRegWrite,
   input  logic            inMemtoReg,
   input  logic            inBranch,
   input  logic            inMemWrite,
   input  logic            inMemRead,
   output logic            dmemReqValid,
   input  logic            dmemReqReady,
   output logic [XLEN-1:0] dmemAddr,
   output logic [XLEN-1:0] dmemWData,
   output logic            dmemWe,
   input  logic            dmemRspValid,
   input  logic [XLEN-1:0] dmemRData,
   output logic            stall,
   output logic            pcSrc,
   output logic [XLEN-1:0] pcBranch,
   output logic [XLEN-1:0] wbReadData,
   output logic [XLEN-1:0] wbALUOutput,
   output logic [4:0]      wbRd,
   output logic            wbRegWrite,
   output logic            wbMemtoReg,
   output logic            memErr
);

   // Last count value before a wait is abandoned.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;
   logic [XLEN-1:0]    ldbuf_q, ldbuf_d;
   logic               req_valid_q, req_valid_d;

   logic               memop;
   logic               expired;
   logic               stall_raw;
   logic               capture;
   logic [XLEN-1:0]    wb_rdata;

   assign memop   = is_memop(inMemRead, inMemWrite);
   assign expired = (cnt_q == CNT_LAST);

   // Transaction sequencing, wait counter, load buffer and sticky error.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      ldbuf_d = ldbuf_q;
      case (state_q)
         ST_IDLE: begin
            if (memop) begin
               state_d = ST_REQ;
               cnt_d   = '0;
            end
         end
         ST_REQ: begin
            // A handshake on the last allowed cycle still completes.
            if (dmemReqReady) begin
               state_d = inMemWrite ? ST_DONE : ST_RSP;
               cnt_d   = '0;
            end else if (expired) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
               ldbuf_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RSP: begin
            if (dmemRspValid) begin
               state_d = ST_DONE;
               ldbuf_d = dmemRData;
            end else if (expired) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
               ldbuf_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      req_valid_d = (state_d == ST_REQ);
   end

   // Stage state; request valid is registered alongside the state it decodes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         ldbuf_q     <= '0;
         req_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         ldbuf_q     <= ldbuf_d;
         req_valid_q <= req_valid_d;
      end
   end

   // Stall and MEM/WB load control: the entry is taken in IDLE for a
   // non-memory instruction and in DONE for a memory one; otherwise a bubble.
   always_comb begin
      stall_raw = 1'b0;
      capture   = 1'b0;
      wb_rdata  = '0;
      case (state_q)
         ST_IDLE: begin
            stall_raw = memop;
            capture   = !memop;
         end
         ST_REQ,
         ST_RSP:  stall_raw = 1'b1;
         ST_DONE: begin
            capture  = 1'b1;
            wb_rdata = inMemWrite ? '0 : ldbuf_q;
         end
         default: stall_raw = 1'b0;
      endcase
   end

   // Request fields are shown only while a request is outstanding; upstream
   // is frozen by stall, so they stay stable until the handshake.
   assign dmemReqValid = req_valid_q;
   assign dmemAddr     = req_valid_q ? inALUOutput : '0;
   assign dmemWData    = req_valid_q ? inReadData2 : '0;
   assign dmemWe       = req_valid_q & inMemWrite;

   // Reset also forces the combinational stage outputs low.
   assign stall    = rst & stall_raw;
   assign pcSrc    = rst & inBranch & inZero & (state_q == ST_IDLE) & !memop;
   assign pcBranch = inPCBranch;
   assign memErr   = err_q;

   memwb_regs #(
      .XLEN (XLEN)
   ) u_memwb (
      .clk          (clk),
      .rst          (rst),
      .en           (capture),
      .bubble       (!capture),
      .inReadData   (wb_rdata),
      .inALUOutput  (inALUOutput),
      .inRd         (inRd),
      .inRegWrite   (inRegWrite),
      .inMemtoReg   (inMemtoReg),
      .outReadData  (wbReadData),
      .outALUOutput (wbALUOutput),
      .outRd        (wbRd),
      .outRegWrite  (wbRegWrite),
      .outMemtoReg  (wbMemtoReg)
   );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases followed by random
// instructions, each checked against a transaction-level model of stall
// length, MEM/WB contents, branch decision and the sticky error flag.
module tb_mem_stage;

   localparam int XLEN = 32;
   localparam int TO   = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [XLEN-1:0] inPCBranch = '0;
   logic            inZero = 1'b0;
   logic [XLEN-1:0] inALUOutput = '0;
   logic [XLEN-1:0] inReadData2 = '0;
   logic [4:0]      inRd = '0;
   logic            inRegWrite = 1'b0, inMemtoReg = 1'b0, inBranch = 1'b0;
   logic            inMemWrite = 1'b0, inMemRead = 1'b0;
   logic            dmemReqValid;
   logic            dmemReqReady = 1'b0;
   logic [XLEN-1:0] dmemAddr, dmemWData;
   logic            dmemWe;
   logic            dmemRspValid = 1'b0;
   logic [XLEN-1:0] dmemRData = '0;
   logic            stall, pcSrc;
   logic [XLEN-1:0] pcBranch, wbReadData, wbALUOutput;
   logic [4:0]      wbRd;
   logic            wbRegWrite, wbMemtoReg, memErr;

   int checks = 0;
   int errors = 0;
   bit err_exp = 1'b0;

   mem_stage #(.TIMEOUT(TO), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst),
      .inPCBranch(inPCBranch), .inZero(inZero), .inALUOutput(inALUOutput),
      .inReadData2(inReadData2), .inRd(inRd), .inRegWrite(inRegWrite),
      .inMemtoReg(inMemtoReg), .inBranch(inBranch), .inMemWrite(inMemWrite),
      .inMemRead(inMemRead),
      .dmemReqValid(dmemReqValid), .dmemReqReady(dmemReqReady),
      .dmemAddr(dmemAddr), .dmemWData(dmemWData), .dmemWe(dmemWe),
      .dmemRspValid(dmemRspValid), .dmemRData(dmemRData),
      .stall(stall), .pcSrc(pcSrc), .pcBranch(pcBranch),
      .wbReadData(wbReadData), .wbALUOutput(wbALUOutput), .wbRd(wbRd),
      .wbRegWrite(wbRegWrite), .wbMemtoReg(wbMemtoReg), .memErr(memErr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      inPCBranch = '0; inZero = 0; inALUOutput = '0; inReadData2 = '0; inRd = '0;
      inRegWrite = 0; inMemtoReg = 0; inBranch = 0; inMemWrite = 0; inMemRead = 0;
      dmemReqReady = 0; dmemRspValid = 0; dmemRData = '0;
   endtask

   // kind: 0 = ALU, 1 = load, 2 = store, 3 = load+store (store wins).
   // ready_wait: REQ cycles before ready; rsp_wait: RSP cycles before response.
   // Called just after a rising edge with the stage in IDLE.
   task automatic run_instr(input bit [1:0] kind, input logic regw, input logic m2r,
                            input logic br, input logic zero, input logic [4:0] rd,
                            input logic [31:0] alu, input logic [31:0] wdata,
                            input logic [31:0] pcb, input logic [31:0] rdata,
                            input int ready_wait, input int rsp_wait);
      bit memop, is_store, tmo, done, in_rsp, prev_stall, hs, was_valid;
      int exp_stall, cyc, stall_n, pc_bad, bubble_bad, bus_bad, req_idx, rsp_idx;
      logic [31:0] exp_rdata;

      // Reference model: cycles spent stalled and what lands in MEM/WB.
      memop    = (kind != 2'd0);
      is_store = kind[1];
      tmo      = 0;
      exp_rdata = '0;
      if (!memop)                 exp_stall = 0;
      else if (ready_wait >= TO)  begin exp_stall = 1 + TO; tmo = 1; end
      else if (is_store)          exp_stall = 2 + ready_wait;
      else if (rsp_wait >= TO)    begin exp_stall = 2 + ready_wait + TO; tmo = 1; end
      else                        begin exp_stall = 3 + ready_wait + rsp_wait; exp_rdata = rdata; end
      err_exp = err_exp | tmo;

      inMemRead = kind[0]; inMemWrite = kind[1]; inRegWrite = regw; inMemtoReg = m2r;
      inBranch = br; inZero = zero; inRd = rd; inALUOutput = alu; inReadData2 = wdata;
      inPCBranch = pcb;

      cyc = 0; stall_n = 0; pc_bad = 0; bubble_bad = 0; bus_bad = 0;
      req_idx = 0; rsp_idx = 0; in_rsp = 0; prev_stall = 0; done = 0;
      while (!done && cyc < 60) begin
         // Memory responder; stray response pulses during REQ must be ignored.
         dmemReqReady = 0; dmemRspValid = 0; dmemRData = $urandom;
         if (dmemReqValid) begin
            dmemReqReady = (req_idx >= ready_wait);
            dmemRspValid = 1'($urandom_range(0, 1));
         end else if (in_rsp && rsp_idx == rsp_wait) begin
            dmemRspValid = 1;
            dmemRData    = rdata;
         end
         @(negedge clk);
         if (cyc == 0) begin
            check("pcSrc", 32'(pcSrc), 32'(br & zero & !memop));
            check("pcBranch", pcBranch, pcb);
         end
         if (stall) begin
            stall_n++;
            if (pcSrc) pc_bad++;
         end
         if (prev_stall && wbRegWrite) bubble_bad++;
         if (dmemReqValid && (dmemAddr !== alu || dmemWData !== wdata || dmemWe !== is_store))
            bus_bad++;
         if (!stall) done = 1;
         prev_stall = stall;
         was_valid  = dmemReqValid;
         hs         = dmemReqValid & dmemReqReady;
         @(posedge clk); #1;
         if (in_rsp) rsp_idx++;
         if (hs && !is_store) in_rsp = 1;
         if (was_valid && !hs) req_idx++;
         cyc++;
      end
      dmemReqReady = 0; dmemRspValid = 0;

      check("completed_in_budget", 32'(done), 32'd1);
      check("stall_cycles", 32'(stall_n), 32'(exp_stall));
      check("pcSrc_during_stall", 32'(pc_bad), 32'd0);
      check("bubble_regwrite", 32'(bubble_bad), 32'd0);
      check("req_fields_stable", 32'(bus_bad), 32'd0);
      check("wbRegWrite", 32'(wbRegWrite), 32'(regw));
      check("wbMemtoReg", 32'(wbMemtoReg), 32'(m2r));
      check("wbRd", 32'(wbRd), 32'(rd));
      check("wbALUOutput", wbALUOutput, alu);
      check("wbReadData", wbReadData, exp_rdata);
      check("memErr", 32'(memErr), 32'(err_exp));
      check("req_idle_after", 32'(dmemReqValid), 32'd0);
   endtask

   initial begin
      // Reset holds everything low, even with a memory op presented.
      clear_inputs();
      inMemRead = 1;
      #2;
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_reqvalid", 32'(dmemReqValid), 32'd0);
      check("rst_wbRegWrite", 32'(wbRegWrite), 32'd0);
      check("rst_wbReadData", wbReadData, 32'd0);
      check("rst_memErr", 32'(memErr), 32'd0);
      clear_inputs();
      @(negedge clk); rst = 1;
      @(posedge clk); #1;

      // Directed cases.
      run_instr(2'd0, 1, 0, 0, 0, 5'd5, 32'h1234, 32'h0, 32'h0, 32'h0, 0, 0);
      run_instr(2'd1, 1, 1, 0, 0, 5'd7, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 0, 0);
      run_instr(2'd2, 0, 0, 0, 0, 5'd0, 32'h200, 32'hCAFEF00D, 32'h0, 32'h0, 4, 0);
      run_instr(2'd0, 0, 0, 1, 1, 5'd0, 32'h0, 32'h0, 32'h40, 32'h0, 0, 0);
      run_instr(2'd0, 0, 0, 1, 0, 5'd0, 32'h0, 32'h0, 32'h40, 32'h0, 0, 0);
      run_instr(2'd1, 1, 1, 1, 1, 5'd9, 32'h300, 32'h0, 32'h80, 32'h55AA55AA, 7, 7);
      run_instr(2'd3, 1, 0, 0, 0, 5'd3, 32'h400, 32'h11112222, 32'h0, 32'h0, 1, 0);
      run_instr(2'd1, 1, 1, 0, 0, 5'd4, 32'h500, 32'h0, 32'h0, 32'h12345678, 100, 0);
      run_instr(2'd1, 1, 1, 0, 0, 5'd6, 32'h600, 32'h0, 32'h0, 32'h87654321, 2, 100);

      // Random instructions.
      for (int i = 0; i < 40; i++) begin
         int rw, sw;
         rw = ($urandom_range(0, 7) == 0) ? 8 + $urandom_range(0, 3) : $urandom_range(0, 5);
         sw = ($urandom_range(0, 7) == 0) ? 8 + $urandom_range(0, 3) : $urandom_range(0, 5);
         run_instr(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 5'($urandom), $urandom, $urandom, $urandom, $urandom, rw, sw);
      end

      // Reset while waiting in RSP: outputs drop at once, late response ignored.
      inMemRead = 1; inRegWrite = 1; inMemtoReg = 1; inRd = 5'd12; inALUOutput = 32'h700;
      @(posedge clk); #1;
      dmemReqReady = 1;
      @(posedge clk); #1;
      dmemReqReady = 0;
      @(posedge clk); #2;
      clear_inputs();
      rst = 0;
      #1;
      err_exp = 0;
      check("midrst_reqvalid", 32'(dmemReqValid), 32'd0);
      check("midrst_stall", 32'(stall), 32'd0);
      check("midrst_pcSrc", 32'(pcSrc), 32'd0);
      check("midrst_wbRegWrite", 32'(wbRegWrite), 32'd0);
      check("midrst_wbALUOutput", wbALUOutput, 32'd0);
      check("midrst_memErr", 32'(memErr), 32'd0);
      @(negedge clk); rst = 1;
      @(posedge clk); #1;
      dmemRspValid = 1; dmemRData = 32'hBADC0DE5;
      @(negedge clk);
      check("late_rsp_stall", 32'(stall), 32'd0);
      check("late_rsp_reqvalid", 32'(dmemReqValid), 32'd0);
      @(posedge clk); #1;
      dmemRspValid = 0;
      @(negedge clk);
      check("late_rsp_wbReadData", wbReadData, 32'd0);
      check("late_rsp_wbRegWrite", 32'(wbRegWrite), 32'd0);
      @(posedge clk); #1;

      // Stage runs normally after the reset.
      run_instr(2'd0, 1, 0, 0, 0, 5'd21, 32'hABCD, 32'h0, 32'h0, 32'h0, 0, 0);
      run_instr(2'd1, 1, 1, 0, 0, 5'd22, 32'h800, 32'h0, 32'h0, 32'h0F0F0F0F, 1, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
